ui_display: RTL and testbench

- Output-side counterpart to the UI switch/trigger path. The input side detects a UI change and pulses a trigger; this block consumes that trigger.
- On each trigger it latches the new parameter ID and value, echoes the value on the board LEDs, and shows ID/value in hex on the 8-digit multiplexed seven-segment display.
- It also asserts a timed "recently changed" flag, used by the LED/status logic.
- Sits between the UI handler and the board I/O pins.

---
 rtl/ui_display.sv | 144 ++++++++++++++
 tb/tb_ui_display.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ui_display.sv
// ui_display: latches the parameter ID/value on each UI trigger, echoes the
// value on the LEDs, scans ID/value in hex across an 8-digit multiplexed
// seven-segment display, and holds a timed "recently changed" flag.
module ui_display #(
   parameter int DIGIT_PERIOD = 100_000,
   parameter int FLASH_CYCLES = 50_000_000
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        update_trig_in,
   input  logic [7:0]  param_id_in,
   input  logic [15:0] data_in,
   output logic [6:0]  cat_out,
   output logic [7:0]  an_out,
   output logic [15:0] led_out,
   output logic        flash_active_out
);

   localparam int PW = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
   localparam int FW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;

   typedef enum logic {
      IDLE,
      ACTIVE
   } flashState_t;

   logic [15:0]   val_q;
   logic [7:0]    id_q;
   logic [PW-1:0] periodCnt_q;
   logic [2:0]    idx_q;
   logic [FW-1:0] flashCnt_q;
   flashState_t   flashState_q;
   logic          flash_q;
   logic [7:0]    an_q, an_d;
   logic [6:0]    cat_q, cat_d;
   logic [3:0]    nibble;
   logic          blank;

   // Capture the new ID/value whenever the UI path pulses its trigger
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         val_q <= '0;
         id_q  <= '0;
      end else if (update_trig_in) begin
         val_q <= data_in;
         id_q  <= param_id_in;
      end
   end

   // Dwell on each digit for DIGIT_PERIOD cycles, then step to the next digit
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         periodCnt_q <= '0;
         idx_q       <= '0;
      end else if (periodCnt_q == PW'(DIGIT_PERIOD - 1)) begin
         periodCnt_q <= '0;
         idx_q       <= idx_q + 3'd1;
      end else begin
         periodCnt_q <= periodCnt_q + PW'(1);
      end
   end

   // Pick the nibble for the current digit and form the next anode/cathode pattern
   always_comb begin
      nibble = 4'h0;
      blank  = 1'b0;
      an_d   = 8'hFF;
      cat_d  = 7'h7F;
      case (idx_q)
         3'd0: nibble = val_q[3:0];
         3'd1: nibble = val_q[7:4];
         3'd2: nibble = val_q[11:8];
         3'd3: nibble = val_q[15:12];
         3'd4: nibble = id_q[3:0];
         3'd5: nibble = id_q[7:4];
         default: blank = 1'b1;
      endcase
      if (!blank) begin
         an_d = ~(8'd1 << idx_q);
         case (nibble)
            4'h0: cat_d = 7'b1000000;
            4'h1: cat_d = 7'b1111001;
            4'h2: cat_d = 7'b0100100;
            4'h3: cat_d = 7'b0110000;
            4'h4: cat_d = 7'b0011001;
            4'h5: cat_d = 7'b0010010;
            4'h6: cat_d = 7'b0000010;
            4'h7: cat_d = 7'b1111000;
            4'h8: cat_d = 7'b0000000;
            4'h9: cat_d = 7'b0010000;
            4'hA: cat_d = 7'b0001000;
            4'hB: cat_d = 7'b0000011;
            4'hC: cat_d = 7'b1000110;
            4'hD: cat_d = 7'b0100001;
            4'hE: cat_d = 7'b0000110;
            default: cat_d = 7'b0001110;
         endcase
      end
   end

   // Register the display drive so the pins never see decode glitches
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         an_q  <= 8'hFF;
         cat_q <= 7'h7F;
      end else begin
         an_q  <= an_d;
         cat_q <= cat_d;
      end
   end

   // Flash window: a trigger (re)loads the countdown, expiry returns to idle
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         flashState_q <= IDLE;
         flashCnt_q   <= '0;
         flash_q      <= 1'b0;
      end else if (update_trig_in) begin
         flashState_q <= ACTIVE;
         flashCnt_q   <= FW'(FLASH_CYCLES - 1);
         flash_q      <= 1'b1;
      end else begin
         case (flashState_q)
            ACTIVE: begin
               if (flashCnt_q == '0) begin
                  flashState_q <= IDLE;
                  flash_q      <= 1'b0;
               end else begin
                  flashCnt_q <= flashCnt_q - FW'(1);
               end
            end
            default: begin
               flash_q <= 1'b0;
            end
         endcase
      end
   end

   assign an_out           = an_q;
   assign cat_out          = cat_q;
   assign led_out          = val_q;
   assign flash_active_out = flash_q;

endmodule

// File: tb/tb_ui_display.sv
// tb_ui_display: randomized and directed stimulus for ui_display, checked
// against a cycle-count based reference model of the display scan and flash.
module tb_ui_display;

   localparam int DP = 4;
   localparam int FC = 20;

   logic        clk_in;
   logic        rst_in;
   logic        update_trig_in;
   logic [7:0]  param_id_in;
   logic [15:0] data_in;
   logic [6:0]  cat_out;
   logic [7:0]  an_out;
   logic [15:0] led_out;
   logic        flash_active_out;

   int passCount;
   int checkCount;

   int          edgeNum;
   int          lastTrig;
   logic [15:0] mVal;
   logic [7:0]  mId;
   logic [6:0]  segTable [16];

   ui_display #(
      .DIGIT_PERIOD(DP),
      .FLASH_CYCLES(FC)
   ) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .update_trig_in(update_trig_in),
      .param_id_in(param_id_in),
      .data_in(data_in),
      .cat_out(cat_out),
      .an_out(an_out),
      .led_out(led_out),
      .flash_active_out(flash_active_out)
   );

   // Free-running 10-unit clock
   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   // Compare one observed value against its expected value and tally it
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", tag, observed, expected, edgeNum);
      end
   endtask

   // Drive one cycle of inputs, advance the model with the clock, then compare all outputs
   task automatic applyStimulus(input logic trig, input logic [7:0] id, input logic [15:0] data);
      int          shownIdx;
      logic [15:0] prevVal;
      logic [7:0]  prevId;
      logic [3:0]  nib;
      logic [7:0]  expAn;
      logic [6:0]  expCat;
      int          zeros;
      update_trig_in = trig;
      param_id_in    = id;
      data_in        = data;
      @(posedge clk_in);
      prevVal  = mVal;
      prevId   = mId;
      shownIdx = (edgeNum / DP) % 8;
      edgeNum++;
      if (trig) begin
         mVal     = data;
         mId      = id;
         lastTrig = edgeNum;
      end
      expAn  = 8'hFF;
      expCat = 7'h7F;
      if (shownIdx < 6) begin
         if (shownIdx < 4) nib = 4'((prevVal >> (4 * shownIdx)) & 16'hF);
         else              nib = 4'((prevId >> (4 * (shownIdx - 4))) & 8'hF);
         expAn  = 8'hFF;
         expAn[shownIdx] = 1'b0;
         expCat = segTable[nib];
      end
      #1;
      update_trig_in = 1'b0;
      checkOutput("an", 32'(an_out), 32'(expAn));
      checkOutput("cat", 32'(cat_out), 32'(expCat));
      checkOutput("led", 32'(led_out), 32'(mVal));
      checkOutput("flash", 32'(flash_active_out),
                  32'((lastTrig >= 0) && (edgeNum - lastTrig < FC)));
      zeros = 0;
      for (int i = 0; i < 8; i++) if (an_out[i] == 1'b0) zeros++;
      checkOutput("ghost", 32'(zeros <= 1), 32'd1);
   endtask

   // Put the model back to its post-reset state
   task automatic resetModel();
      edgeNum  = 0;
      lastTrig = -1;
      mVal     = '0;
      mId      = '0;
   endtask

   // Directed scenarios followed by a long random run
   initial begin
      passCount  = 0;
      checkCount = 0;
      segTable = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                   7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                   7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      resetModel();
      update_trig_in = 1'b0;
      param_id_in    = '0;
      data_in        = '0;
      rst_in         = 1'b0;
      #23;
      checkOutput("rst_an", 32'(an_out), 32'hFF);
      checkOutput("rst_cat", 32'(cat_out), 32'h7F);
      checkOutput("rst_led", 32'(led_out), 32'h0);
      checkOutput("rst_flash", 32'(flash_active_out), 32'h0);
      @(negedge clk_in);
      rst_in = 1'b1;

      // Idle scan showing zeros
      for (int i = 0; i < 34; i++) applyStimulus(1'b0, 8'h00, 16'h0000);

      // Load 3A/BEEF and watch a full scan plus the flash window
      applyStimulus(1'b1, 8'h3A, 16'hBEEF);
      for (int i = 0; i < 9; i++) applyStimulus(1'b0, 8'h00, 16'h0000);
      applyStimulus(1'b1, 8'h3A, 16'hBEEF);
      for (int i = 0; i < 36; i++) applyStimulus(1'b0, 8'h00, 16'h0000);

      // Trigger exactly on the edge that advances the scan into digit 0
      while (((edgeNum + 1) % (DP * 8)) != 0) applyStimulus(1'b0, 8'h00, 16'h0000);
      applyStimulus(1'b1, 8'h12, 16'h0001);
      applyStimulus(1'b0, 8'h00, 16'h0000);
      checkOutput("coinc_an", 32'(an_out), 32'hFE);
      checkOutput("coinc_cat", 32'(cat_out), 32'b1111001);

      // Back-to-back triggers
      applyStimulus(1'b1, 8'hC4, 16'h1234);
      applyStimulus(1'b1, 8'h5D, 16'hA5A5);
      applyStimulus(1'b0, 8'h00, 16'h0000);

      // Asynchronous reset mid-scan while the flash window is running
      applyStimulus(1'b1, 8'hFF, 16'hFFFF);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, 16'h0000);
      #2;
      rst_in = 1'b0;
      #1;
      checkOutput("mid_an", 32'(an_out), 32'hFF);
      checkOutput("mid_cat", 32'(cat_out), 32'h7F);
      checkOutput("mid_led", 32'(led_out), 32'h0);
      checkOutput("mid_flash", 32'(flash_active_out), 32'h0);
      resetModel();
      @(negedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b1;
      for (int i = 0; i < 40; i++) applyStimulus(1'b0, 8'h00, 16'h0000);

      // Random triggers
      for (int i = 0; i < 10000; i++) begin
         applyStimulus(($urandom_range(0, 15) == 0), 8'($urandom), 16'($urandom));
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
